// File: rtl/wbi_slave_port_mn.sv
// Daisy-chain interconnect node with NS local slave channels.
// Commands are decoded against per-slave base/mask windows and pass through
// a one-entry register stage to a local channel, the next node, or the local
// decode-error generator. Responses from all NS+2 sources are merged upstream
// by a round-robin arbiter that stays locked on one source for a whole burst.
module wbi_slave_port_mn #(
  parameter int              NS        = 2,
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              BW        = 4,
  parameter int              BL        = 10,
  parameter logic [NS*AW-1:0] BASE     = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0] MASK     = {32'hF000_0000, 32'hF000_0000},
  parameter bit              LAST_NODE = 1'b0
) (
  input  logic             mclk,
  input  logic             reset_n,
  // upstream command
  input  logic             wbp_cmd_wval_i,
  output logic             wbp_cmd_wrdy_o,
  input  logic [AW-1:0]    wbp_cmd_adr_i,
  input  logic             wbp_cmd_we_i,
  input  logic [DW-1:0]    wbp_cmd_dat_i,
  input  logic [BW-1:0]    wbp_cmd_sel_i,
  input  logic [3:0]       wbp_cmd_tid_i,
  input  logic [BL-1:0]    wbp_cmd_bl_i,
  // upstream response
  output logic             wbp_res_rval_o,
  input  logic             wbp_res_rrdy_i,
  output logic [DW-1:0]    wbp_res_dat_o,
  output logic             wbp_res_ack_o,
  output logic             wbp_res_lack_o,
  output logic             wbp_res_err_o,
  output logic [3:0]       wbp_res_tid_o,
  // local commands
  output logic [NS-1:0]    wbl_cmd_wval_o,
  input  logic [NS-1:0]    wbl_cmd_wrdy_i,
  output logic [NS*AW-1:0] wbl_cmd_adr_o,
  output logic [NS-1:0]    wbl_cmd_we_o,
  output logic [NS*DW-1:0] wbl_cmd_dat_o,
  output logic [NS*BW-1:0] wbl_cmd_sel_o,
  output logic [NS*4-1:0]  wbl_cmd_tid_o,
  output logic [NS*BL-1:0] wbl_cmd_bl_o,
  // local responses
  input  logic [NS-1:0]    wbl_res_rval_i,
  output logic [NS-1:0]    wbl_res_rrdy_o,
  input  logic [NS*DW-1:0] wbl_res_dat_i,
  input  logic [NS-1:0]    wbl_res_ack_i,
  input  logic [NS-1:0]    wbl_res_lack_i,
  input  logic [NS-1:0]    wbl_res_err_i,
  input  logic [NS*4-1:0]  wbl_res_tid_i,
  // downstream command
  output logic             wbd_cmd_wval_o,
  input  logic             wbd_cmd_wrdy_i,
  output logic [AW-1:0]    wbd_cmd_adr_o,
  output logic             wbd_cmd_we_o,
  output logic [DW-1:0]    wbd_cmd_dat_o,
  output logic [BW-1:0]    wbd_cmd_sel_o,
  output logic [3:0]       wbd_cmd_tid_o,
  output logic [BL-1:0]    wbd_cmd_bl_o,
  // downstream response
  input  logic             wbd_res_rval_i,
  output logic             wbd_res_rrdy_o,
  input  logic [DW-1:0]    wbd_res_dat_i,
  input  logic             wbd_res_ack_i,
  input  logic             wbd_res_lack_i,
  input  logic             wbd_res_err_i,
  input  logic [3:0]       wbd_res_tid_i
);

  localparam int NC = NS + 1;            // stages carrying a full payload
  localparam int NR = NS + 2;            // response requesters
  localparam int PW = $clog2(NR);
  localparam logic [PW-1:0] DWN = PW'(NS);
  localparam logic [PW-1:0] ERR = PW'(NS + 1);
  localparam logic [PW:0]   NRW = (PW+1)'(NR);

  // ---------------- decode ----------------
  logic [NS-1:0] hit;
  logic [PW-1:0] dest;

  for (genvar i = 0; i < NS; i++) begin : g_hit
    assign hit[i] = (wbp_cmd_adr_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW];
  end

  // Lowest matching slave wins; misses go downstream or to the error generator
  always_comb begin
    dest = LAST_NODE ? ERR : DWN;
    for (int i = NS - 1; i >= 0; i--)
      if (hit[i]) dest = PW'(i);
  end

  // ---------------- command stages ----------------
  logic [NC-1:0]          full_q, full_d, cwrdy;
  logic [NC-1:0][AW-1:0]  adr_q, adr_d;
  logic [NC-1:0]          we_q, we_d;
  logic [NC-1:0][DW-1:0]  dat_q, dat_d;
  logic [NC-1:0][BW-1:0]  sel_q, sel_d;
  logic [NC-1:0][3:0]     tid_q, tid_d;
  logic [NC-1:0][BL-1:0]  bl_q, bl_d;
  logic                   err_full_q, err_full_d;
  logic [3:0]             err_tid_q, err_tid_d;
  logic [NR-1:0]          dst_rdy;
  logic                   cmd_acc;
  logic                   err_take;

  assign cwrdy          = {wbd_cmd_wrdy_i & !LAST_NODE, wbl_cmd_wrdy_i};
  // The error generator only takes a command when it has nothing pending
  assign dst_rdy        = {!err_full_q, ~full_q | cwrdy};
  assign wbp_cmd_wrdy_o = dst_rdy[dest];
  assign cmd_acc        = wbp_cmd_wval_i & wbp_cmd_wrdy_o;

  // Stage next state: drain on wrdy, refill wins over drain in the same cycle
  always_comb begin
    full_d = full_q; adr_d = adr_q; we_d = we_q; dat_d = dat_q;
    sel_d  = sel_q;  tid_d = tid_q; bl_d = bl_q;
    for (int g = 0; g < NC; g++) begin
      if (full_q[g] && cwrdy[g]) full_d[g] = 1'b0;
      if (cmd_acc && dest == PW'(g)) begin
        full_d[g] = 1'b1;
        adr_d[g]  = wbp_cmd_adr_i;
        we_d[g]   = wbp_cmd_we_i;
        dat_d[g]  = wbp_cmd_dat_i;
        sel_d[g]  = wbp_cmd_sel_i;
        tid_d[g]  = wbp_cmd_tid_i;
        bl_d[g]   = wbp_cmd_bl_i;
      end
    end
    err_full_d = err_full_q;
    err_tid_d  = err_tid_q;
    if (err_take) err_full_d = 1'b0;
    if (cmd_acc && dest == ERR) begin
      err_full_d = 1'b1;
      err_tid_d  = wbp_cmd_tid_i;
    end
  end

  // Stage registers
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      full_q <= '0; adr_q <= '0; we_q <= '0; dat_q <= '0;
      sel_q  <= '0; tid_q <= '0; bl_q <= '0;
      err_full_q <= 1'b0;
      err_tid_q  <= '0;
    end else begin
      full_q <= full_d; adr_q <= adr_d; we_q <= we_d; dat_q <= dat_d;
      sel_q  <= sel_d;  tid_q <= tid_d; bl_q <= bl_d;
      err_full_q <= err_full_d;
      err_tid_q  <= err_tid_d;
    end
  end

  assign wbl_cmd_wval_o = full_q[NS-1:0];
  assign wbl_cmd_we_o   = we_q[NS-1:0];
  for (genvar i = 0; i < NS; i++) begin : g_lcmd
    assign wbl_cmd_adr_o[i*AW +: AW] = adr_q[i];
    assign wbl_cmd_dat_o[i*DW +: DW] = dat_q[i];
    assign wbl_cmd_sel_o[i*BW +: BW] = sel_q[i];
    assign wbl_cmd_tid_o[i*4 +: 4]   = tid_q[i];
    assign wbl_cmd_bl_o[i*BL +: BL]  = bl_q[i];
  end

  assign wbd_cmd_wval_o = full_q[NS] & !LAST_NODE;
  assign wbd_cmd_adr_o  = adr_q[NS];
  assign wbd_cmd_we_o   = we_q[NS];
  assign wbd_cmd_dat_o  = dat_q[NS];
  assign wbd_cmd_sel_o  = sel_q[NS];
  assign wbd_cmd_tid_o  = tid_q[NS];
  assign wbd_cmd_bl_o   = bl_q[NS];

  // ---------------- response arbitration ----------------
  logic [NR-1:0] req;
  logic [PW-1:0] ptr_q, ptr_d, hold_q, hold_d, arb_idx, gnt;
  logic          lock_q, lock_d, arb_hit, gnt_vld, res_acc;
  logic [PW:0]   sum;

  assign req = {err_full_q, wbd_res_rval_i & !LAST_NODE, wbl_res_rval_i};

  // Circular search for the first requester at or after the pointer
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    sum     = '0;
    for (int k = 0; k < NR; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NRW) sum = sum - NRW;
      if (!arb_hit && req[sum[PW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = sum[PW-1:0];
      end
    end
  end

  // While locked the burst owner keeps the grant even if it drops rval
  assign gnt            = lock_q ? hold_q : arb_idx;
  assign gnt_vld        = lock_q | arb_hit;
  assign wbp_res_rval_o = gnt_vld & req[gnt];
  assign res_acc        = wbp_res_rval_o & wbp_res_rrdy_i;
  assign err_take       = res_acc && (gnt == ERR);

  // Mux the granted source upstream; only the granted source sees rrdy
  always_comb begin
    wbp_res_dat_o  = '0;
    wbp_res_ack_o  = 1'b0;
    wbp_res_lack_o = 1'b0;
    wbp_res_err_o  = 1'b0;
    wbp_res_tid_o  = '0;
    wbl_res_rrdy_o = '0;
    wbd_res_rrdy_o = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (gnt == PW'(i)) begin
        wbp_res_dat_o     = wbl_res_dat_i[i*DW +: DW];
        wbp_res_ack_o     = wbl_res_ack_i[i];
        wbp_res_lack_o    = wbl_res_lack_i[i];
        wbp_res_err_o     = wbl_res_err_i[i];
        wbp_res_tid_o     = wbl_res_tid_i[i*4 +: 4];
        wbl_res_rrdy_o[i] = gnt_vld & wbp_res_rrdy_i;
      end
    end
    if (gnt == DWN) begin
      wbp_res_dat_o  = wbd_res_dat_i;
      wbp_res_ack_o  = wbd_res_ack_i;
      wbp_res_lack_o = wbd_res_lack_i;
      wbp_res_err_o  = wbd_res_err_i;
      wbp_res_tid_o  = wbd_res_tid_i;
      wbd_res_rrdy_o = gnt_vld & wbp_res_rrdy_i & !LAST_NODE;
    end
    if (gnt == ERR) begin
      // single terminating error beat, data zero
      wbp_res_err_o  = 1'b1;
      wbp_res_lack_o = 1'b1;
      wbp_res_tid_o  = err_tid_q;
    end
  end

  // Lock on a non-last beat, release and advance the pointer on the last
  always_comb begin
    lock_d = lock_q;
    hold_d = hold_q;
    ptr_d  = ptr_q;
    if (res_acc) begin
      if (!wbp_res_lack_o) begin
        lock_d = 1'b1;
        hold_d = gnt;
      end else begin
        lock_d = 1'b0;
        ptr_d  = (gnt == ERR) ? '0 : gnt + PW'(1);
      end
    end
  end

  // Arbiter state registers
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
      hold_q <= '0;
      ptr_q  <= '0;
    end else begin
      lock_q <= lock_d;
      hold_q <= hold_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: tb/tb_wbi_slave_port_mn.sv
// Directed bench for wbi_slave_port_mn: routing, stage throughput and
// backpressure, error termination (LAST_NODE=1 instance), burst locking and
// round-robin response order. Command and response beats are tracked in
// scoreboard queues filled when stimulus is driven.
module tb_wbi_slave_port_mn;

  logic mclk = 1'b0;
  logic reset_n;
  always #5 mclk = ~mclk;

  // node under test (LAST_NODE=0)
  logic        wval, wrdy_o, we, rval_o, rrdy, ack_o, lack_o, err_o;
  logic [31:0] adr, dat, rdat_o;
  logic [3:0]  sel, tid, rtid_o;
  logic [9:0]  bl;
  logic [1:0]  lc_wval_o, lc_wrdy, lc_we_o, lr_rval, lr_rrdy_o, lr_ack, lr_lack, lr_err;
  logic [63:0] lc_adr_o, lc_dat_o, lr_dat;
  logic [7:0]  lc_sel_o, lc_tid_o, lr_tid;
  logic [19:0] lc_bl_o;
  logic        dc_wval_o, dc_wrdy, dc_we_o, dr_rval, dr_rrdy_o, dr_ack, dr_lack, dr_err;
  logic [31:0] dc_adr_o, dc_dat_o, dr_dat;
  logic [3:0]  dc_sel_o, dc_tid_o, dr_tid;
  logic [9:0]  dc_bl_o;

  // terminal node (LAST_NODE=1)
  logic        u_wval, u_wrdy_o, u_rval_o, u_rrdy, u_ack_o, u_lack_o, u_err_o;
  logic [31:0] u_adr, u_rdat_o;
  logic [3:0]  u_tid, u_rtid_o;
  logic [1:0]  u_lc_wval_o, u_lc_we_o, u_lr_rval, u_lr_rrdy_o;
  logic [63:0] u_lc_adr_o, u_lc_dat_o;
  logic [7:0]  u_lc_sel_o, u_lc_tid_o;
  logic [19:0] u_lc_bl_o;
  logic        u_dc_wval_o, u_dc_we_o, u_dr_rrdy_o;
  logic [31:0] u_dc_adr_o, u_dc_dat_o;
  logic [3:0]  u_dc_sel_o, u_dc_tid_o;
  logic [9:0]  u_dc_bl_o;

  wbi_slave_port_mn dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbp_cmd_wval_i(wval), .wbp_cmd_wrdy_o(wrdy_o), .wbp_cmd_adr_i(adr), .wbp_cmd_we_i(we),
    .wbp_cmd_dat_i(dat), .wbp_cmd_sel_i(sel), .wbp_cmd_tid_i(tid), .wbp_cmd_bl_i(bl),
    .wbp_res_rval_o(rval_o), .wbp_res_rrdy_i(rrdy), .wbp_res_dat_o(rdat_o), .wbp_res_ack_o(ack_o),
    .wbp_res_lack_o(lack_o), .wbp_res_err_o(err_o), .wbp_res_tid_o(rtid_o),
    .wbl_cmd_wval_o(lc_wval_o), .wbl_cmd_wrdy_i(lc_wrdy), .wbl_cmd_adr_o(lc_adr_o), .wbl_cmd_we_o(lc_we_o),
    .wbl_cmd_dat_o(lc_dat_o), .wbl_cmd_sel_o(lc_sel_o), .wbl_cmd_tid_o(lc_tid_o), .wbl_cmd_bl_o(lc_bl_o),
    .wbl_res_rval_i(lr_rval), .wbl_res_rrdy_o(lr_rrdy_o), .wbl_res_dat_i(lr_dat), .wbl_res_ack_i(lr_ack),
    .wbl_res_lack_i(lr_lack), .wbl_res_err_i(lr_err), .wbl_res_tid_i(lr_tid),
    .wbd_cmd_wval_o(dc_wval_o), .wbd_cmd_wrdy_i(dc_wrdy), .wbd_cmd_adr_o(dc_adr_o), .wbd_cmd_we_o(dc_we_o),
    .wbd_cmd_dat_o(dc_dat_o), .wbd_cmd_sel_o(dc_sel_o), .wbd_cmd_tid_o(dc_tid_o), .wbd_cmd_bl_o(dc_bl_o),
    .wbd_res_rval_i(dr_rval), .wbd_res_rrdy_o(dr_rrdy_o), .wbd_res_dat_i(dr_dat), .wbd_res_ack_i(dr_ack),
    .wbd_res_lack_i(dr_lack), .wbd_res_err_i(dr_err), .wbd_res_tid_i(dr_tid)
  );

  wbi_slave_port_mn #(.LAST_NODE(1'b1)) dut1 (
    .mclk(mclk), .reset_n(reset_n),
    .wbp_cmd_wval_i(u_wval), .wbp_cmd_wrdy_o(u_wrdy_o), .wbp_cmd_adr_i(u_adr), .wbp_cmd_we_i(we),
    .wbp_cmd_dat_i(dat), .wbp_cmd_sel_i(sel), .wbp_cmd_tid_i(u_tid), .wbp_cmd_bl_i(bl),
    .wbp_res_rval_o(u_rval_o), .wbp_res_rrdy_i(u_rrdy), .wbp_res_dat_o(u_rdat_o), .wbp_res_ack_o(u_ack_o),
    .wbp_res_lack_o(u_lack_o), .wbp_res_err_o(u_err_o), .wbp_res_tid_o(u_rtid_o),
    .wbl_cmd_wval_o(u_lc_wval_o), .wbl_cmd_wrdy_i(lc_wrdy), .wbl_cmd_adr_o(u_lc_adr_o), .wbl_cmd_we_o(u_lc_we_o),
    .wbl_cmd_dat_o(u_lc_dat_o), .wbl_cmd_sel_o(u_lc_sel_o), .wbl_cmd_tid_o(u_lc_tid_o), .wbl_cmd_bl_o(u_lc_bl_o),
    .wbl_res_rval_i(u_lr_rval), .wbl_res_rrdy_o(u_lr_rrdy_o), .wbl_res_dat_i(lr_dat), .wbl_res_ack_i(lr_ack),
    .wbl_res_lack_i(lr_lack), .wbl_res_err_i(lr_err), .wbl_res_tid_i(lr_tid),
    .wbd_cmd_wval_o(u_dc_wval_o), .wbd_cmd_wrdy_i(dc_wrdy), .wbd_cmd_adr_o(u_dc_adr_o), .wbd_cmd_we_o(u_dc_we_o),
    .wbd_cmd_dat_o(u_dc_dat_o), .wbd_cmd_sel_o(u_dc_sel_o), .wbd_cmd_tid_o(u_dc_tid_o), .wbd_cmd_bl_o(u_dc_bl_o),
    .wbd_res_rval_i(dr_rval), .wbd_res_rrdy_o(u_dr_rrdy_o), .wbd_res_dat_i(dr_dat), .wbd_res_ack_i(dr_ack),
    .wbd_res_lack_i(dr_lack), .wbd_res_err_i(dr_err), .wbd_res_tid_i(dr_tid)
  );

  typedef struct { int dst; logic [31:0] adr; logic [31:0] dat; logic [3:0] tid; } cmd_t;
  typedef struct { logic [3:0] tid; logic [31:0] dat; logic lack; } res_t;
  cmd_t cq[$];
  res_t rq[$];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  // Drive an upstream command on the node under test; optionally expect it
  task automatic cmd(input logic [31:0] a, input logic [3:0] t, input logic [31:0] d, input int dst, input bit exp);
    cmd_t c;
    wval = 1'b1; adr = a; tid = t; dat = d; we = 1'b1; sel = 4'hF; bl = 10'd4;
    if (exp) begin
      c.dst = dst; c.adr = a; c.dat = d; c.tid = t;
      cq.push_back(c);
    end
  endtask

  task automatic rexp(input logic [3:0] t, input logic [31:0] d, input logic l);
    res_t r;
    r.tid = t; r.dat = d; r.lack = l;
    rq.push_back(r);
  endtask

  // One clock: retire beats transferring at the coming edge, then advance
  task automatic tick();
    logic [2:0]       cv;
    logic [2:0][31:0] ca, cd;
    logic [2:0][3:0]  ct;
    cmd_t c;
    res_t r;
    #1;
    if (mon_en) begin
      cv = {dc_wval_o & dc_wrdy, lc_wval_o & lc_wrdy};
      ca = {dc_adr_o, lc_adr_o};
      cd = {dc_dat_o, lc_dat_o};
      ct = {dc_tid_o, lc_tid_o};
      for (int d = 0; d < 3; d++) begin
        if (cv[d]) begin
          if (cq.size() == 0) chk("cmd_extra", 64'(cv[d]), 64'd0);
          else begin
            c = cq.pop_front();
            chk("cmd_dst", 64'(d), 64'(c.dst));
            chk("cmd_adr", 64'(ca[d]), 64'(c.adr));
            chk("cmd_dat", 64'(cd[d]), 64'(c.dat));
            chk("cmd_tid", 64'(ct[d]), 64'(c.tid));
          end
        end
      end
      if (rval_o && rrdy) begin
        if (rq.size() == 0) chk("res_extra", 64'(rval_o), 64'd0);
        else begin
          r = rq.pop_front();
          chk("res_tid", 64'(rtid_o), 64'(r.tid));
          chk("res_dat", 64'(rdat_o), 64'(r.dat));
          chk("res_lack", 64'(lack_o), 64'(r.lack));
          chk("res_err", 64'(err_o), 64'd0);
        end
      end
    end
    @(posedge mclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with inputs active ----
    reset_n = 1'b0;
    wval = 1'b1; adr = 32'h1000_0040; we = 1'b1; dat = 32'h5; sel = 4'hF; tid = 4'h3; bl = 10'd1;
    lc_wrdy = 2'b11; dc_wrdy = 1'b1; rrdy = 1'b1;
    lr_rval = 2'b11; lr_dat = {32'hA1, 32'hA0}; lr_ack = 2'b11; lr_lack = 2'b11; lr_err = 2'b00;
    lr_tid = {4'h1, 4'h0};
    dr_rval = 1'b1; dr_dat = 32'hDD; dr_ack = 1'b1; dr_lack = 1'b1; dr_err = 1'b0; dr_tid = 4'hD;
    u_wval = 1'b1; u_adr = 32'h8000_0000; u_tid = 4'h5; u_rrdy = 1'b1; u_lr_rval = 2'b00;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_lc_wval", 64'(lc_wval_o), 64'd0);
    chk("rst_dc_wval", 64'(dc_wval_o), 64'd0);
    chk("rst_u_rval", 64'(u_rval_o), 64'd0);
    chk("rst_u_lc_wval", 64'(u_lc_wval_o), 64'd0);
    wval = 1'b0; lr_rval = 2'b00; dr_rval = 1'b0; u_wval = 1'b0; adr = 32'h0;
    reset_n = 1'b1;
    @(posedge mclk);
    #1;
    chk("rel_wrdy", 64'(wrdy_o), 64'd1);
    chk("rel_rval", 64'(rval_o), 64'd0);
    chk("rel_lc_wval", 64'(lc_wval_o), 64'd0);
    chk("rel_dc_wval", 64'(dc_wval_o), 64'd0);
    chk("rel_u_wrdy", 64'(u_wrdy_o), 64'd1);
    mon_en = 1'b1;

    // ---- slave1 routing, 4 back-to-back beats ----
    cmd(32'h1000_0040, 4'h3, 32'hCAFE_0000, 1, 1'b1);
    #1 chk("s1_wrdy", 64'(wrdy_o), 64'd1);
    tick();
    chk("s1_wval", 64'(lc_wval_o), 64'b10);
    chk("s1_adr", 64'(lc_adr_o[63:32]), 64'h1000_0040);
    chk("s1_tid", 64'(lc_tid_o[7:4]), 64'h3);
    chk("s1_dc_idle", 64'(dc_wval_o), 64'd0);
    for (int b = 1; b < 4; b++) begin
      cmd(32'h1000_0040 + 32'(4*b), 4'h3, 32'hCAFE_0000 + 32'(b), 1, 1'b1);
      #1 chk("s1_stream_wrdy", 64'(wrdy_o), 64'd1);
      tick();
      chk("s1_stream_wval", 64'(lc_wval_o), 64'b10);
    end
    wval = 1'b0;
    tick();
    chk("s1_drained", 64'(lc_wval_o), 64'd0);
    chk("s1_cq_empty", 64'(cq.size()), 64'd0);

    // ---- backpressure, then drain + refill in one cycle ----
    lc_wrdy = 2'b01;
    cmd(32'h1000_0100, 4'h4, 32'h0000_0100, 1, 1'b1);
    tick();
    cmd(32'h1000_0104, 4'h4, 32'h0000_0104, 1, 1'b0);
    #1 chk("bp_wrdy_low", 64'(wrdy_o), 64'd0);
    tick();
    chk("bp_hold_adr", 64'(lc_adr_o[63:32]), 64'h1000_0100);
    lc_wrdy = 2'b11;
    cmd(32'h1000_0104, 4'h4, 32'h0000_0104, 1, 1'b1);
    #1 chk("bp_wrdy_back", 64'(wrdy_o), 64'd1);
    tick();
    chk("refill_wval", 64'(lc_wval_o), 64'b10);
    chk("refill_adr", 64'(lc_adr_o[63:32]), 64'h1000_0104);
    wval = 1'b0;
    tick();

    // ---- downstream miss and slave0 hit ----
    cmd(32'h8000_0000, 4'h7, 32'h0000_1234, 2, 1'b1);
    #1 chk("dn_wrdy", 64'(wrdy_o), 64'd1);
    tick();
    chk("dn_wval", 64'(dc_wval_o), 64'd1);
    chk("dn_lc_idle", 64'(lc_wval_o), 64'd0);
    chk("dn_adr", 64'(dc_adr_o), 64'h8000_0000);
    cmd(32'h0000_0010, 4'h2, 32'h0000_0010, 0, 1'b1);
    tick();
    chk("s0_wval", 64'(lc_wval_o), 64'b01);
    wval = 1'b0;
    tick();
    chk("cmd_cq_empty", 64'(cq.size()), 64'd0);

    // ---- LAST_NODE=1: unmatched command terminates with an error beat ----
    u_rrdy = 1'b0; u_wval = 1'b1; u_adr = 32'h8000_0000; u_tid = 4'h5;
    #1 chk("e_wrdy", 64'(u_wrdy_o), 64'd1);
    tick();
    u_adr = 32'h9000_0000; u_tid = 4'h6;
    #1 chk("e_busy_wrdy", 64'(u_wrdy_o), 64'd0);
    chk("e_rval", 64'(u_rval_o), 64'd1);
    chk("e_err", 64'(u_err_o), 64'd1);
    chk("e_lack", 64'(u_lack_o), 64'd1);
    chk("e_ack", 64'(u_ack_o), 64'd0);
    chk("e_dat", 64'(u_rdat_o), 64'd0);
    chk("e_tid", 64'(u_rtid_o), 64'h5);
    chk("e_dn_tied", 64'({u_dc_wval_o, u_dr_rrdy_o}), 64'd0);
    tick();
    chk("e_tid_hold", 64'(u_rtid_o), 64'h5);
    u_wval = 1'b0; u_rrdy = 1'b1;
    tick();
    chk("e_cleared", 64'(u_rval_o), 64'd0);
    u_rrdy = 1'b0; u_lr_rval = 2'b11;
    #1 chk("e_wrap_gnt", 64'(u_rtid_o), 64'h0);
    chk("e_wrap_rval", 64'(u_rval_o), 64'd1);
    u_lr_rval = 2'b00;

    // ---- slave0 4-beat burst vs. waiting downstream, with stalls ----
    lr_rval = 2'b01; lr_lack = 2'b00; lr_dat = {32'hA1, 32'hB0};
    dr_rval = 1'b1; dr_lack = 1'b1;
    rexp(4'h0, 32'hB0, 1'b0);
    #1 chk("b0_rrdy", 64'({dr_rrdy_o, lr_rrdy_o}), 64'b001);
    tick();
    rrdy = 1'b0; lr_dat[31:0] = 32'hB1;
    repeat (5) begin
      #1 chk("stall_rval", 64'(rval_o), 64'd1);
      chk("stall_tid", 64'(rtid_o), 64'h0);
      chk("stall_dat", 64'(rdat_o), 64'hB1);
      chk("stall_rrdy", 64'({dr_rrdy_o, lr_rrdy_o}), 64'd0);
      tick();
    end
    lr_rval = 2'b00; rrdy = 1'b1;
    #1 chk("gap_rval", 64'(rval_o), 64'd0);
    chk("gap_dn_held", 64'(dr_rrdy_o), 64'd0);
    tick();
    lr_rval = 2'b01;
    for (int b = 1; b < 4; b++) begin
      lr_dat[31:0] = 32'hB0 + 32'(b);
      lr_lack[0] = (b == 3);
      rexp(4'h0, 32'hB0 + 32'(b), b == 3);
      #1 chk("burst_rrdy", 64'({dr_rrdy_o, lr_rrdy_o}), 64'b001);
      tick();
    end
    lr_dat[31:0] = 32'hE0;
    rexp(4'hD, 32'hDD, 1'b1);
    rexp(4'h0, 32'hE0, 1'b1);
    #1 chk("post_dn_gnt", 64'({dr_rrdy_o, lr_rrdy_o}), 64'b100);
    tick();
    #1 chk("post_s0_gnt", 64'({dr_rrdy_o, lr_rrdy_o}), 64'b001);
    tick();
    lr_rval = 2'b00; dr_rval = 1'b0;
    chk("burst_rq_empty", 64'(rq.size()), 64'd0);

    // ---- round robin with every requester valid, pointer starts at 1 ----
    lr_rval = 2'b11; dr_rval = 1'b1; lr_lack = 2'b11; lr_dat = {32'hA1, 32'hA0};
    rexp(4'h1, 32'hA1, 1'b1); rexp(4'hD, 32'hDD, 1'b1); rexp(4'h0, 32'hA0, 1'b1);
    rexp(4'h1, 32'hA1, 1'b1); rexp(4'hD, 32'hDD, 1'b1); rexp(4'h0, 32'hA0, 1'b1);
    repeat (6) begin
      #1 chk("rr_rval", 64'(rval_o), 64'd1);
      tick();
    end
    lr_rval = 2'b00; dr_rval = 1'b0;
    tick();
    chk("rr_rq_empty", 64'(rq.size()), 64'd0);
    chk("end_cq_empty", 64'(cq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
